lc3b_ctrl_fsm: RTL and testbench

LC3B_CTRL_FSM -- requirements
Module: lc3b_ctrl_fsm

---
 rtl/lc3b_ctrl_fsm.sv | 204 ++++++++++++++++++++
 tb/tb_lc3b_ctrl_fsm.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_ctrl_fsm.sv
// Control FSM for a small LC-3b style datapath: fetch, decode, execute,
// memory and write-back sequencing with a bounded memory wait and sticky error flags.
module lc3b_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned BYTE_EN     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  input  logic        done,
  output logic        mem_L,
  output logic        mem_S,
  output logic        mem_word,
  output logic        load_ir,
  output logic        load_pc,
  output logic        load_mar,
  output logic        load_mdr,
  output logic        reg_w,
  output logic        genCC,
  output logic [1:0]  pc_mux,
  output logic        mar_mux,
  output logic        mdr_mux_ctrl,
  output logic [1:0]  dr_in_mux,
  output logic [1:0]  alu_control,
  output logic [2:0]  state,
  output logic        halted,
  output logic        illegal,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    FETCH0 = 3'd0, FETCH1 = 3'd1, FETCH2 = 3'd2, DECODE = 3'd3,
    EXEC   = 3'd4, MEM    = 3'd5, WB     = 3'd6, HALT   = 3'd7
  } state_t;

  localparam int unsigned   CW      = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO     = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam bit            BEN     = (BYTE_EN != 0);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          ill_q, ill_d, tmo_q, tmo_d;
  logic          tmo_hit;

  logic [3:0] op;
  logic       is_add, is_and, is_xor, is_alu, is_br, is_jmp, is_lea;
  logic       is_ldw, is_stw, is_ldb, is_stb, is_load, is_store, is_legal;
  logic       br_taken;
  logic       unused_ir;

  assign op       = ir[15:12];
  assign is_add   = (op == 4'b0001);
  assign is_and   = (op == 4'b0101);
  assign is_xor   = (op == 4'b1001);
  assign is_alu   = is_add | is_and | is_xor;
  assign is_br    = (op == 4'b0000);
  assign is_jmp   = (op == 4'b1100);
  assign is_lea   = (op == 4'b1110);
  assign is_ldw   = (op == 4'b0110);
  assign is_stw   = (op == 4'b0111);
  assign is_ldb   = BEN && (op == 4'b0010);
  assign is_stb   = BEN && (op == 4'b0011);
  assign is_load  = is_ldw | is_ldb;
  assign is_store = is_stw | is_stb;
  assign is_legal = is_alu | is_br | is_jmp | is_lea | is_load | is_store;
  assign br_taken = (ir[11] & N) | (ir[10] & Z) | (ir[9] & P);
  assign unused_ir = ^ir[8:0];

  // Counter saturates rather than wrapping so a disabled timeout never aliases.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  assign tmo_hit = (MEM_TIMEOUT != 0) && (cnt_q == TMO);

  assign state       = rst ? 3'd0 : state_q;
  assign illegal     = ill_q & ~rst;
  assign timeout_err = tmo_q & ~rst;

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    ill_d        = ill_q;
    tmo_d        = tmo_q;
    mem_L        = 1'b0;
    mem_S        = 1'b0;
    mem_word     = 1'b0;
    load_ir      = 1'b0;
    load_pc      = 1'b0;
    load_mar     = 1'b0;
    load_mdr     = 1'b0;
    reg_w        = 1'b0;
    genCC        = 1'b0;
    pc_mux       = 2'b00;
    mar_mux      = 1'b0;
    mdr_mux_ctrl = 1'b0;
    dr_in_mux    = 2'b00;
    alu_control  = 2'b00;
    halted       = 1'b0;
    if (!rst) begin
      unique case (state_q)
        FETCH0: begin
          load_mar = 1'b1;
          load_pc  = 1'b1;
          state_d  = FETCH1;
        end
        FETCH1: begin
          mem_L    = 1'b1;
          mem_word = 1'b1;
          if (done) begin
            load_mdr = 1'b1;
            state_d  = FETCH2;
          end else if (tmo_hit) begin
            state_d = HALT;
            tmo_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        FETCH2: begin
          load_ir = 1'b1;
          state_d = DECODE;
        end
        DECODE: begin
          if (is_legal) begin
            state_d = EXEC;
          end else begin
            state_d = HALT;
            ill_d   = 1'b1;
          end
        end
        EXEC: begin
          state_d = FETCH0;
          if (is_alu) begin
            reg_w       = 1'b1;
            genCC       = 1'b1;
            alu_control = is_and ? 2'b01 : (is_xor ? 2'b10 : 2'b00);
          end
          if (is_br && br_taken) begin
            load_pc = 1'b1;
            pc_mux  = 2'b01;
          end
          if (is_jmp) begin
            load_pc = 1'b1;
            pc_mux  = 2'b10;
          end
          if (is_lea) begin
            reg_w     = 1'b1;
            dr_in_mux = 2'b10;
          end
          if (is_load || is_store) begin
            load_mar = 1'b1;
            mar_mux  = 1'b1;
            state_d  = MEM;
          end
          if (is_store) begin
            load_mdr     = 1'b1;
            mdr_mux_ctrl = 1'b1;
          end
        end
        MEM: begin
          mem_word = is_ldw | is_stw;
          mem_S    = is_store;
          mem_L    = ~is_store;
          if (done) begin
            load_mdr = ~is_store;
            state_d  = is_store ? FETCH0 : WB;
          end else if (tmo_hit) begin
            state_d = HALT;
            tmo_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        WB: begin
          reg_w     = 1'b1;
          dr_in_mux = 2'b01;
          genCC     = 1'b1;
          state_d   = FETCH0;
        end
        HALT: begin
          halted = 1'b1;
        end
        default: state_d = FETCH0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_lc3b_ctrl_fsm.sv
// Directed bench for lc3b_ctrl_fsm: three instances (default, MEM_TIMEOUT=4,
// BYTE_EN=0) share stimulus; outputs are packed into one vector per check.
module tb_lc3b_ctrl_fsm;

  logic        clk, rst, N, Z, P, done;
  logic [15:0] ir;

  logic       mem_L_w[3], mem_S_w[3], mem_word_w[3], load_ir_w[3], load_pc_w[3];
  logic       load_mar_w[3], load_mdr_w[3], reg_w_w[3], genCC_w[3], mar_mux_w[3];
  logic       mdr_w[3], halted_w[3], illegal_w[3], tmo_w[3];
  logic [1:0] pc_mux_w[3], dr_w[3], alu_w[3];
  logic [2:0] state_w[3];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    lc3b_ctrl_fsm #(
      .MEM_TIMEOUT((g == 1) ? 4 : 15),
      .BYTE_EN    ((g == 2) ? 0 : 1)
    ) u_dut (
      .clk(clk), .rst(rst), .ir(ir), .N(N), .Z(Z), .P(P), .done(done),
      .mem_L(mem_L_w[g]), .mem_S(mem_S_w[g]), .mem_word(mem_word_w[g]),
      .load_ir(load_ir_w[g]), .load_pc(load_pc_w[g]), .load_mar(load_mar_w[g]),
      .load_mdr(load_mdr_w[g]), .reg_w(reg_w_w[g]), .genCC(genCC_w[g]),
      .pc_mux(pc_mux_w[g]), .mar_mux(mar_mux_w[g]), .mdr_mux_ctrl(mdr_w[g]),
      .dr_in_mux(dr_w[g]), .alu_control(alu_w[g]), .state(state_w[g]),
      .halted(halted_w[g]), .illegal(illegal_w[g]), .timeout_err(tmo_w[g])
    );
  end

  localparam logic [22:0] ML    = 23'(1) << 22;
  localparam logic [22:0] MS    = 23'(1) << 21;
  localparam logic [22:0] MW    = 23'(1) << 20;
  localparam logic [22:0] LIR   = 23'(1) << 19;
  localparam logic [22:0] LPC   = 23'(1) << 18;
  localparam logic [22:0] LMAR  = 23'(1) << 17;
  localparam logic [22:0] LMDR  = 23'(1) << 16;
  localparam logic [22:0] RW    = 23'(1) << 15;
  localparam logic [22:0] GCC   = 23'(1) << 14;
  localparam logic [22:0] PC01  = 23'(1) << 12;
  localparam logic [22:0] PC10  = 23'(2) << 12;
  localparam logic [22:0] MARM  = 23'(1) << 11;
  localparam logic [22:0] MDRM  = 23'(1) << 10;
  localparam logic [22:0] DR01  = 23'(1) << 8;
  localparam logic [22:0] DR10  = 23'(2) << 8;
  localparam logic [22:0] ALU01 = 23'(1) << 6;
  localparam logic [22:0] ALU10 = 23'(2) << 6;
  localparam logic [22:0] HLT   = 23'(1) << 5;
  localparam logic [22:0] ILL   = 23'(1) << 4;
  localparam logic [22:0] TMO   = 23'(1) << 3;
  localparam logic [22:0] S0 = 23'd0, S1 = 23'd1, S2 = 23'd2, S3 = 23'd3;
  localparam logic [22:0] S4 = 23'd4, S5 = 23'd5, S6 = 23'd6, S7 = 23'd7;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [22:0] obs(int g);
    return {mem_L_w[g], mem_S_w[g], mem_word_w[g], load_ir_w[g], load_pc_w[g],
            load_mar_w[g], load_mdr_w[g], reg_w_w[g], genCC_w[g], pc_mux_w[g],
            mar_mux_w[g], mdr_w[g], dr_w[g], alu_w[g], halted_w[g], illegal_w[g],
            tmo_w[g], state_w[g]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int g, input logic [22:0] exp);
    logic [22:0] o;
    #1;
    o = obs(g);
    checks++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, g, o, exp);
    end
  endtask

  task automatic reset_all;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // From FETCH0 with done on the first FETCH1 cycle; returns in the state after DECODE.
  task automatic fetch_decode;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; ir = 16'h1042; done = 1'b0; N = 1'b0; Z = 1'b0; P = 1'b0;
    tick();
    tick();
    chk("rst_outs", 0, S0);
    chk("rst_outs_t4", 1, S0);
    rst = 1'b0;

    chk("add_fetch0", 0, LMAR | LPC | S0);
    tick(); done = 1'b1;
    chk("add_fetch1", 0, ML | MW | LMDR | S1);
    tick(); done = 1'b0;
    chk("add_fetch2", 0, LIR | S2);
    tick();
    chk("add_decode", 0, S3);
    tick();
    chk("add_exec", 0, RW | GCC | S4);
    tick();
    chk("add_back", 0, LMAR | LPC | S0);

    ir = 16'h2000;
    fetch_decode();
    chk("ldb_exec", 0, LMAR | MARM | S4);
    tick();
    chk("ldb_wait", 0, ML | S5);
    tick();
    tick();
    tick(); done = 1'b1;
    chk("ldb_done", 0, ML | LMDR | S5);
    tick(); done = 1'b0;
    chk("ldb_wb", 0, RW | GCC | DR01 | S6);
    tick();

    ir = 16'h0400; Z = 1'b1;
    fetch_decode();
    chk("br_taken", 0, LPC | PC01 | S4);
    tick();
    Z = 1'b0; N = 1'b1;
    fetch_decode();
    chk("br_not_taken", 0, S4);
    tick();
    ir = 16'h0000; N = 1'b1; Z = 1'b1; P = 1'b1;
    fetch_decode();
    chk("br_nzp000", 0, S4);
    tick();
    N = 1'b0; Z = 1'b0; P = 1'b0;

    ir = 16'hC000; fetch_decode();
    chk("jmp_exec", 0, LPC | PC10 | S4);
    tick();
    ir = 16'hE000; fetch_decode();
    chk("lea_exec", 0, RW | DR10 | S4);
    tick();
    ir = 16'h5000; fetch_decode();
    chk("and_exec", 0, RW | GCC | ALU01 | S4);
    tick();
    ir = 16'h9000; fetch_decode();
    chk("xor_exec", 0, RW | GCC | ALU10 | S4);
    tick();

    ir = 16'h7000; fetch_decode();
    chk("stw_exec", 0, LMAR | MARM | LMDR | MDRM | S4);
    tick();
    chk("stw_mem", 0, MS | MW | S5);
    rst = 1'b1;
    chk("stw_rst_drop", 0, S0);
    tick();
    rst = 1'b0; done = 1'b1;
    chk("stw_resume", 0, LMAR | LPC | S0);
    tick(); done = 1'b0;
    chk("stw_refetch", 0, ML | MW | S1);

    reset_all();
    ir = 16'hD000; fetch_decode();
    chk("shf_halt", 0, HLT | ILL | S7);
    done = 1'b1;
    tick(); done = 1'b0;
    chk("shf_stays", 0, HLT | ILL | S7);
    rst = 1'b1;
    chk("shf_rst", 0, S0);
    tick(); rst = 1'b0;
    chk("shf_cleared", 0, LMAR | LPC | S0);

    ir = 16'h3000; fetch_decode();
    chk("stb_exec", 0, LMAR | MARM | LMDR | MDRM | S4);
    chk("noben_stb_ill", 2, HLT | ILL | S7);

    reset_all();
    done = 1'b0;
    tick();
    tick();
    tick();
    tick();
    tick();
    chk("tmo_last_wait", 1, ML | MW | S1);
    tick();
    chk("tmo_halt", 1, HLT | TMO | S7);
    chk("tmo15_waiting", 0, ML | MW | S1);
    rst = 1'b1;
    chk("tmo_rst", 1, S0);
    tick(); rst = 1'b0;
    chk("tmo_cleared", 1, LMAR | LPC | S0);

    tick();
    tick();
    tick();
    tick();
    tick(); done = 1'b1;
    chk("tmo_done_same", 1, ML | MW | LMDR | S1);
    tick(); done = 1'b0;
    chk("tmo_done_wins", 1, LIR | S2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
